// File: rtl/bridge_io_pkg.sv
// Shared address map, decode selector and active-low 7-segment glyphs for the CPU I/O bridge.
// Pure declarations: no latency, no flow control.
package bridge_io_pkg;

  localparam logic [31:0] IO_BASE       = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_DIG      = 32'hFFFF_F000;
  localparam logic [31:0] ADDR_TMR      = 32'hFFFF_F020;
  localparam logic [31:0] ADDR_TMR_CTRL = 32'hFFFF_F024;
  localparam logic [31:0] ADDR_LED      = 32'hFFFF_F060;
  localparam logic [31:0] ADDR_SW       = 32'hFFFF_F070;
  localparam logic [31:0] ADDR_BTN      = 32'hFFFF_F078;

  // Segment order {G,F,E,D,C,B,A}, a 0 lights the segment.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [15:0][6:0] SEG_LUT = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                          SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

  typedef enum logic [2:0] {
    SEL_DRAM,
    SEL_DIG,
    SEL_TMR,
    SEL_CTRL,
    SEL_LED,
    SEL_SW,
    SEL_BTN,
    SEL_NONE
  } sel_e;

  function automatic sel_e decode_sel(input logic [31:0] a);
    sel_e s;
    s = SEL_NONE;
    if (a < IO_BASE) begin
      s = SEL_DRAM;
    end else begin
      case (a)
        ADDR_DIG:      s = SEL_DIG;
        ADDR_TMR:      s = SEL_TMR;
        ADDR_TMR_CTRL: s = SEL_CTRL;
        ADDR_LED:      s = SEL_LED;
        ADDR_SW:       s = SEL_SW;
        ADDR_BTN:      s = SEL_BTN;
        default:       s = SEL_NONE;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/bridge_io_if.sv
// CPU MEM-stage data port: address, store strobe/data out, load data back.
// Load data is combinational on the address; the port has no stall or backpressure.
interface bridge_io_if;
  logic [31:0] addr_from_cpu;
  logic        wen_from_cpu;
  logic [31:0] wdata_from_cpu;
  logic [31:0] rdata_to_cpu;

  modport master (
    output addr_from_cpu,
    output wen_from_cpu,
    output wdata_from_cpu,
    input  rdata_to_cpu
  );

  modport slave (
    input  addr_from_cpu,
    input  wen_from_cpu,
    input  wdata_from_cpu,
    output rdata_to_cpu
  );
endinterface

// File: rtl/bridge_io_seg7_decode.sv
// Hex nibble to active-low {G..A} segment pattern.
// Combinational, zero latency, no flow control.
module seg7_decode
  import bridge_io_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[hex];
endmodule

// File: rtl/bridge_io.sv
// Bus bridge from CPU data port to DRAM and board peripherals; optional timer under BRIDGE_TIMER_EN.
// Loads return combinationally, stores commit on the clock edge; never stalls the CPU.
module bridge_io
  import bridge_io_pkg::*;
#(
  parameter int SCAN_DIV  = 20000,
  parameter int TMR_PRESC = 100
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  bridge_io_if.slave  cpu,
  output logic [13:0] dram_addr,
  output logic        dram_we,
  output logic [31:0] dram_wdata,
  input  logic [31:0] dram_rdata,
  input  logic [23:0] sw,
  input  logic [4:0]  btn,
  output logic [23:0] led,
  output logic [7:0]  dig_en,
  output logic [7:0]  dig_seg
);

  localparam int SCAN_W = $clog2(SCAN_DIV);

  if (SCAN_DIV < 2 || TMR_PRESC < 1) begin : g_bad_param
    $error("bridge_io: SCAN_DIV must be >= 2 and TMR_PRESC >= 1");
  end

  logic [31:0] addr;
  logic        wen;
  logic [31:0] wdata;
  sel_e        sel;

  assign addr  = cpu.addr_from_cpu;
  assign wen   = cpu.wen_from_cpu;
  assign wdata = cpu.wdata_from_cpu;
  assign sel   = decode_sel(addr);

  assign dram_addr  = addr[15:2];
  assign dram_we    = wen && (sel == SEL_DRAM);
  assign dram_wdata = wdata;

  logic [31:0]       dig;
  logic [23:0]       sw_s1, sw_s2;
  logic [4:0]        btn_s1, btn_s2;
  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        idx;
  logic              live;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      led      <= '0;
      dig      <= '0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      btn_s1   <= '0;
      btn_s2   <= '0;
      scan_cnt <= '0;
      idx      <= '0;
      live     <= 1'b0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      if (wen && sel == SEL_LED) led <= wdata[23:0];
      if (wen && sel == SEL_DIG) dig <= wdata;
      live <= 1'b1;
      if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= idx + 3'd1;
      end else begin
        scan_cnt <= scan_cnt + SCAN_W'(1);
      end
    end
  end

  // The display stays blank until the first edge after reset so reset forces all-off outputs.
  logic [3:0] nib;
  logic [6:0] seg_raw;

  assign nib = dig[{idx, 2'b00} +: 4];

  seg7_decode u_seg7 (
    .hex (nib),
    .seg (seg_raw)
  );

  assign dig_en  = live ? ~(8'b1 << idx) : 8'hFF;
  assign dig_seg = live ? {1'b1, seg_raw} : 8'hFF;

  logic [31:0] tmr_rdata;
  logic [31:0] ctrl_rdata;

`ifdef BRIDGE_TIMER_EN
  localparam int PRE_W = (TMR_PRESC > 1) ? $clog2(TMR_PRESC) : 1;

  logic [31:0]      tmr;
  logic             run;
  logic [PRE_W-1:0] presc;
  logic             ctrl_wr;
  logic             tick;

  assign ctrl_wr = wen && (sel == SEL_CTRL);
  // A CTRL write restarts the prescaler, so it also cancels a wrap due that cycle.
  assign tick    = run && !ctrl_wr && (presc == PRE_W'(TMR_PRESC - 1));

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      tmr   <= '0;
      run   <= 1'b0;
      presc <= '0;
    end else begin
      if (ctrl_wr) begin
        run   <= wdata[0];
        presc <= '0;
      end else if (run) begin
        presc <= tick ? '0 : presc + PRE_W'(1);
      end
      if (wen && sel == SEL_TMR) tmr <= wdata;
      else if (tick)             tmr <= tmr + 32'd1;
    end
  end

  assign tmr_rdata  = tmr;
  assign ctrl_rdata = {31'b0, run};
`else
  assign tmr_rdata  = '0;
  assign ctrl_rdata = '0;
`endif

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_DRAM: rdata = dram_rdata;
      SEL_DIG:  rdata = dig;
      SEL_TMR:  rdata = tmr_rdata;
      SEL_CTRL: rdata = ctrl_rdata;
      SEL_LED:  rdata = {8'b0, led};
      SEL_SW:   rdata = {8'b0, sw_s2};
      SEL_BTN:  rdata = {27'b0, btn_s2};
      default:  rdata = '0;
    endcase
  end

  assign cpu.rdata_to_cpu = rdata;

endmodule
